// File: rtl/lane_reorder_if.sv
// Tagged lane bus from the deskew stage into lane_reorder, plus reorder status.
// Optional LANE_REORDER_STATS_EN adds the o_mismatch_total counter output.
interface lane_reorder_if #(
    parameter int N_LANES = 20,
    parameter int NB_DATA = 67,
    parameter int NB_ID   = $clog2(N_LANES)
);
    logic                       i_enable;
    logic                       i_valid;
    logic                       i_deskew_done;
    logic [N_LANES-1:0]         i_resync;
    logic [NB_DATA*N_LANES-1:0] i_data;
    logic [NB_ID*N_LANES-1:0]   i_lane_ids;
    logic [NB_DATA*N_LANES-1:0] o_data;
    logic                       o_valid;
    logic                       o_reorder_done;
    logic                       o_invalid_ids;
    logic                       o_align_error;
`ifdef LANE_REORDER_STATS_EN
    logic [15:0]                o_mismatch_total;

    modport master (
        output i_enable, i_valid, i_deskew_done, i_resync, i_data, i_lane_ids,
        input  o_data, o_valid, o_reorder_done, o_invalid_ids, o_align_error, o_mismatch_total
    );
    modport slave (
        input  i_enable, i_valid, i_deskew_done, i_resync, i_data, i_lane_ids,
        output o_data, o_valid, o_reorder_done, o_invalid_ids, o_align_error, o_mismatch_total
    );
`else
    modport master (
        output i_enable, i_valid, i_deskew_done, i_resync, i_data, i_lane_ids,
        input  o_data, o_valid, o_reorder_done, o_invalid_ids, o_align_error
    );
    modport slave (
        input  i_enable, i_valid, i_deskew_done, i_resync, i_data, i_lane_ids,
        output o_data, o_valid, o_reorder_done, o_invalid_ids, o_align_error
    );
`endif
endinterface

// File: rtl/lane_reorder.sv
// Reorders deskewed physical PCS lanes into logical order using AM lane IDs.
// Optional LANE_REORDER_STATS_EN adds a saturating 16-bit mismatch total.
module lane_reorder #(
    parameter int N_LANES      = 20,
    parameter int NB_DATA      = 67,
    parameter int NB_ID        = $clog2(N_LANES),
    parameter int MAX_MISMATCH = 3,
    parameter int NB_DATA_BUS  = NB_DATA * N_LANES,
    parameter int NB_ID_BUS    = NB_ID * N_LANES
) (
    input  logic          i_clock,
    input  logic          i_reset,
    lane_reorder_if.slave bus
);
    localparam int                NB_CNT  = $clog2(MAX_MISMATCH + 1);
    localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(MAX_MISMATCH);

    typedef enum logic [1:0] {IDLE, WAIT_AM, LOCKED} state_t;
    state_t state, state_nxt;

    logic [NB_DATA-1:0]     in_lane  [N_LANES];
    logic [NB_ID-1:0]       in_id    [N_LANES];
    logic [NB_ID-1:0]       map_q    [N_LANES];
    logic [NB_ID-1:0]       map_load [N_LANES];
    logic [N_LANES-1:0]     tags;
    logic [N_LANES-1:0]     id_seen;
    logic [NB_ID_BUS-1:0]   ids_q;
    logic [NB_CNT-1:0]      cnt_q, cnt_nxt;
    logic [NB_DATA_BUS-1:0] data_reord, data_p1;
    logic vld_p1, invalid_p1, align_err_p1;
    logic am_cycle, part_tag, perm_ok, abort, ids_match;
    logic load_map, bad_locked, invalid_pulse, align_pulse;

    function automatic logic [NB_CNT-1:0] sat_inc_cnt(input logic [NB_CNT-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1'b1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        for (int j = 0; j < N_LANES; j++) begin
            in_lane[j] = bus.i_data[NB_DATA_BUS-1-j*NB_DATA -: NB_DATA];
            in_id[j]   = bus.i_lane_ids[NB_ID_BUS-1-j*NB_ID -: NB_ID];
            tags[j]    = in_lane[j][NB_DATA-1];
        end
    end

    // With N_LANES IDs, every value 0..N_LANES-1 being seen implies each appears exactly once
    always_comb begin
        id_seen = '0;
        for (int k = 0; k < N_LANES; k++) begin
            map_load[k] = '0;
            for (int j = 0; j < N_LANES; j++) begin
                if (in_id[j] == NB_ID'(k)) begin
                    id_seen[k]  = 1'b1;
                    map_load[k] = NB_ID'(j);
                end
            end
        end
    end

    assign perm_ok   = &id_seen;
    assign am_cycle  = bus.i_valid & (&tags);
    assign part_tag  = bus.i_valid & (|tags) & ~(&tags);
    assign abort     = (|bus.i_resync) | ~bus.i_deskew_done;
    assign ids_match = (bus.i_lane_ids == ids_q);

    always_comb begin
        data_reord = '0;
        for (int k = 0; k < N_LANES; k++)
            data_reord[NB_DATA_BUS-1-k*NB_DATA -: NB_DATA] = in_lane[map_q[k]];
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)           state <= IDLE;
        else if (bus.i_enable) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = WAIT_AM;
                WAIT_AM: if (am_cycle && perm_ok) state_nxt = LOCKED;
                LOCKED:  if (cnt_nxt == CNT_MAX) state_nxt = WAIT_AM;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        load_map      = 1'b0;
        invalid_pulse = 1'b0;
        align_pulse   = 1'b0;
        bad_locked    = 1'b0;
        cnt_nxt       = '0;
        if (!abort) begin
            case (state)
                WAIT_AM: begin
                    load_map      = am_cycle & perm_ok;
                    invalid_pulse = am_cycle & ~perm_ok;
                    align_pulse   = part_tag;
                end
                LOCKED: begin
                    bad_locked    = part_tag | (am_cycle & ~ids_match);
                    invalid_pulse = am_cycle & ~perm_ok;
                    align_pulse   = part_tag;
                    if (bad_locked)    cnt_nxt = sat_inc_cnt(cnt_q);
                    else if (am_cycle) cnt_nxt = '0;
                    else               cnt_nxt = cnt_q;
                end
                default: ;
            endcase
        end
    end

    // Stage p1: registered reorder output, status pulses and lane map
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt_q        <= '0;
            ids_q        <= '0;
            vld_p1       <= 1'b0;
            invalid_p1   <= 1'b0;
            align_err_p1 <= 1'b0;
            data_p1      <= '0;
            for (int k = 0; k < N_LANES; k++) map_q[k] <= NB_ID'(k);
        end else if (bus.i_enable) begin
            cnt_q        <= cnt_nxt;
            vld_p1       <= bus.i_valid;
            invalid_p1   <= invalid_pulse;
            align_err_p1 <= align_pulse;
            if (bus.i_valid) data_p1 <= data_reord;
            if (load_map) begin
                ids_q <= bus.i_lane_ids;
                map_q <= map_load;
            end else if (state_nxt != LOCKED) begin
                for (int k = 0; k < N_LANES; k++) map_q[k] <= NB_ID'(k);
            end
        end
    end

`ifdef LANE_REORDER_STATS_EN
    logic [15:0] total_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)                         total_q <= '0;
        else if (bus.i_enable && bad_locked) total_q <= sat_inc16(total_q);
    end

    assign bus.o_mismatch_total = total_q;
`endif

    assign bus.o_data         = data_p1;
    assign bus.o_valid        = vld_p1;
    assign bus.o_reorder_done = (state == LOCKED);
    assign bus.o_invalid_ids  = invalid_p1;
    assign bus.o_align_error  = align_err_p1;
endmodule

// File: tb/tb_lane_reorder.sv
// Directed bench for lane_reorder: lock, reorder, mismatch/relock, resync and reset.
module tb_lane_reorder;
    localparam int N_LANES     = 20;
    localparam int NB_DATA     = 67;
    localparam int NB_ID       = 5;
    localparam int NB_DATA_BUS = NB_DATA * N_LANES;
    localparam int NB_ID_BUS   = NB_ID * N_LANES;
    localparam logic [N_LANES-1:0] TAGS_ALL  = '1;
    localparam logic [N_LANES-1:0] TAGS_NONE = '0;
    localparam logic [N_LANES-1:0] TAGS_LO10 = 20'h003FF;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [NB_ID_BUS-1:0] ids_rev, ids_swap, ids_dup;

    lane_reorder_if #(.N_LANES(N_LANES), .NB_DATA(NB_DATA), .NB_ID(NB_ID)) bus ();

    lane_reorder dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [NB_DATA_BUS-1:0] mk_data(input logic [N_LANES-1:0] tags, input int base);
        logic [NB_DATA_BUS-1:0] r;
        r = '0;
        for (int j = 0; j < N_LANES; j++)
            r[NB_DATA_BUS-1-j*NB_DATA -: NB_DATA] = {tags[j], 66'(base + j)};
        return r;
    endfunction

    // Expected output when physical lane j carries logical ID 19-j
    function automatic logic [NB_DATA_BUS-1:0] mk_rev_out(input logic [N_LANES-1:0] tags, input int base);
        logic [NB_DATA_BUS-1:0] r;
        r = '0;
        for (int k = 0; k < N_LANES; k++)
            r[NB_DATA_BUS-1-k*NB_DATA -: NB_DATA] = {tags[N_LANES-1-k], 66'(base + N_LANES - 1 - k)};
        return r;
    endfunction

    function automatic logic [NB_ID_BUS-1:0] set_id(input logic [NB_ID_BUS-1:0] ids, input int j, input int v);
        logic [NB_ID_BUS-1:0] r;
        r = ids;
        r[NB_ID_BUS-1-j*NB_ID -: NB_ID] = NB_ID'(v);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N_LANES-1:0] tags, input int base,
                         input logic [NB_ID_BUS-1:0] ids);
        bus.i_valid    = v;
        bus.i_data     = mk_data(tags, base);
        bus.i_lane_ids = ids;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [NB_DATA_BUS-1:0] exp);
        int bad;
        logic [NB_DATA-1:0] obs_s, exp_s;
        bad   = -1;
        obs_s = '0;
        exp_s = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if (bad < 0 && bus.o_data[NB_DATA_BUS-1-k*NB_DATA -: NB_DATA] !== exp[NB_DATA_BUS-1-k*NB_DATA -: NB_DATA]) begin
                bad   = k;
                obs_s = bus.o_data[NB_DATA_BUS-1-k*NB_DATA -: NB_DATA];
                exp_s = exp[NB_DATA_BUS-1-k*NB_DATA -: NB_DATA];
            end
        end
        checks++;
        assert (bus.o_data === exp)
        else begin
            errors++;
            $error("FAIL %s slot=%0d observed=%0h expected=%0h", tag, bad, obs_s, exp_s);
        end
    endtask

    initial begin
        ids_rev = '0;
        for (int j = 0; j < N_LANES; j++) ids_rev = set_id(ids_rev, j, N_LANES - 1 - j);
        ids_swap = set_id(set_id(ids_rev, 0, 18), 1, 19);
        ids_dup  = '0;
        for (int j = 0; j < N_LANES; j++) ids_dup = set_id(ids_dup, j, j);
        ids_dup = set_id(set_id(ids_dup, 3, 5), 7, 5);

        rst               = 1'b1;
        bus.i_enable      = 1'b0;
        bus.i_deskew_done = 1'b0;
        bus.i_resync      = '0;
        drive(1'b0, TAGS_NONE, 0, ids_rev);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", 64'(bus.o_reorder_done), 64'd0);
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_invalid", 64'(bus.o_invalid_ids), 64'd0);
        chk("rst_align", 64'(bus.o_align_error), 64'd0);
        chk_data("rst_data", '0);
`ifdef LANE_REORDER_STATS_EN
        chk("rst_total", 64'(bus.o_mismatch_total), 64'd0);
`endif

        // IDLE -> WAIT_AM
        rst               = 1'b0;
        bus.i_enable      = 1'b1;
        bus.i_deskew_done = 1'b1;
        step();

        // Duplicate ID at an AM cycle
        drive(1'b1, TAGS_ALL, 200, ids_dup);
        step();
        chk("dup_invalid", 64'(bus.o_invalid_ids), 64'd1);
        chk("dup_done", 64'(bus.o_reorder_done), 64'd0);
        chk("dup_valid", 64'(bus.o_valid), 64'd1);
        chk_data("dup_passthru", mk_data(TAGS_ALL, 200));
        drive(1'b0, TAGS_NONE, 300, ids_rev);
        step();
        chk("dup_pulse_end", 64'(bus.o_invalid_ids), 64'd0);
        chk("idle_valid", 64'(bus.o_valid), 64'd0);
        chk_data("hold_data", mk_data(TAGS_ALL, 200));

        // Partial tags while waiting for an AM
        drive(1'b1, TAGS_LO10, 0, ids_rev);
        step();
        chk("wait_align", 64'(bus.o_align_error), 64'd1);
        chk("wait_align_done", 64'(bus.o_reorder_done), 64'd0);

        // Reversed IDs: lock, AM itself passes through, then reorder
        drive(1'b1, TAGS_ALL, 100, ids_rev);
        step();
        chk("lock_done", 64'(bus.o_reorder_done), 64'd1);
        chk("lock_align", 64'(bus.o_align_error), 64'd0);
        chk_data("lock_am_passthru", mk_data(TAGS_ALL, 100));
        drive(1'b1, TAGS_NONE, 0, ids_rev);
        step();
        chk_data("rev_data", mk_rev_out(TAGS_NONE, 0));
        drive(1'b1, TAGS_NONE, 1000, ids_rev);
        step();
        chk_data("rev_data2", mk_rev_out(TAGS_NONE, 1000));

        // Two bad AMs, one good AM, two bad AMs: stays locked
        drive(1'b1, TAGS_ALL, 0, ids_swap);
        step();
        chk("bad1_done", 64'(bus.o_reorder_done), 64'd1);
        chk("bad1_invalid", 64'(bus.o_invalid_ids), 64'd0);
        step();
        chk("bad2_done", 64'(bus.o_reorder_done), 64'd1);
        drive(1'b1, TAGS_ALL, 0, ids_rev);
        step();
        chk("good_done", 64'(bus.o_reorder_done), 64'd1);
        drive(1'b1, TAGS_ALL, 0, ids_swap);
        step();
        step();
        chk("bad2b_done", 64'(bus.o_reorder_done), 64'd1);
        // Third consecutive bad AM drops lock
        step();
        chk("lost_done", 64'(bus.o_reorder_done), 64'd0);
`ifdef LANE_REORDER_STATS_EN
        chk("lost_total", 64'(bus.o_mismatch_total), 64'd5);
`endif
        drive(1'b1, TAGS_NONE, 0, ids_swap);
        step();
        chk_data("unlock_passthru", mk_data(TAGS_NONE, 0));

        // Relock, then partial tags count as mismatches
        drive(1'b1, TAGS_ALL, 0, ids_rev);
        step();
        chk("relock_done", 64'(bus.o_reorder_done), 64'd1);
        drive(1'b1, TAGS_LO10, 0, ids_rev);
        step();
        chk("part1_align", 64'(bus.o_align_error), 64'd1);
        chk("part1_done", 64'(bus.o_reorder_done), 64'd1);
        step();
        chk("part2_done", 64'(bus.o_reorder_done), 64'd1);
        step();
        chk("part3_align", 64'(bus.o_align_error), 64'd1);
        chk("part3_done", 64'(bus.o_reorder_done), 64'd0);
`ifdef LANE_REORDER_STATS_EN
        chk("part_total", 64'(bus.o_mismatch_total), 64'd8);
`endif

        // Resync while locked, coincident with partial tags
        drive(1'b1, TAGS_ALL, 0, ids_rev);
        step();
        chk("relock2_done", 64'(bus.o_reorder_done), 64'd1);
        bus.i_resync[12] = 1'b1;
        drive(1'b1, TAGS_LO10, 0, ids_rev);
        step();
        chk("resync_done", 64'(bus.o_reorder_done), 64'd0);
        chk("resync_align", 64'(bus.o_align_error), 64'd0);
`ifdef LANE_REORDER_STATS_EN
        chk("resync_total", 64'(bus.o_mismatch_total), 64'd8);
`endif
        bus.i_resync = '0;
        drive(1'b1, TAGS_NONE, 0, ids_rev);
        step();
        chk_data("resync_passthru", mk_data(TAGS_NONE, 0));

        // Enable low holds outputs
        bus.i_enable = 1'b0;
        drive(1'b1, TAGS_NONE, 500, ids_rev);
        step();
        chk_data("enable_hold_data", mk_data(TAGS_NONE, 0));
        chk("enable_hold_valid", 64'(bus.o_valid), 64'd1);
        bus.i_enable = 1'b1;

        // Lock again, then asynchronous reset mid-LOCKED
        drive(1'b1, TAGS_ALL, 0, ids_rev);
        step();
        chk("relock3_done", 64'(bus.o_reorder_done), 64'd1);
        drive(1'b1, TAGS_NONE, 0, ids_rev);
        step();
        chk_data("relock3_data", mk_rev_out(TAGS_NONE, 0));
        #3;
        rst = 1'b1;
        #1;
        chk("async_done", 64'(bus.o_reorder_done), 64'd0);
        chk("async_valid", 64'(bus.o_valid), 64'd0);
        chk_data("async_data", '0);
`ifdef LANE_REORDER_STATS_EN
        chk("async_total", 64'(bus.o_mismatch_total), 64'd0);
`endif
        rst = 1'b0;
        drive(1'b1, TAGS_ALL, 0, ids_rev);
        step();
        chk("post_rst_idle", 64'(bus.o_reorder_done), 64'd0);
        step();
        chk("post_rst_lock", 64'(bus.o_reorder_done), 64'd1);

        // Deskew loss drops lock
        bus.i_deskew_done = 1'b0;
        drive(1'b0, TAGS_NONE, 0, ids_rev);
        step();
        chk("deskew_loss_done", 64'(bus.o_reorder_done), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lane_reorder.md
Name: lane_reorder

Overview:
- Sits directly downstream of the deskew stage and consumes its tagged lane bus. Each lane slot is 67 bits: {start_of_lane tag, 66b block}.
- Once deskew is done, it latches the logical lane ID reported for each physical lane at an aligned alignment-marker (AM) cycle and checks that the IDs form a valid permutation.
- It then outputs the lanes in logical order (logical lane 0 in the MSB slot) and keeps re-checking the IDs at every later AM cycle.
- It feeds the AM removal / decoder stage.

Parameters:
- N_LANES, 20, number of PCS lanes.
- NB_DATA, 67, bits per lane slot ({tag, 66b block}).
- NB_ID, $clog2(N_LANES), bits per lane ID.
- MAX_MISMATCH, 3, consecutive bad AM cycles in LOCKED before relock.
- NB_DATA_BUS, NB_DATA*N_LANES, width of the data bus.
- NB_ID_BUS, NB_ID*N_LANES, width of the ID bus.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  reset, asynchronous, active-high.
- i_enable  in  1  block enable; when low, state and outputs hold.
- i_valid  in  1  input data valid.
- i_deskew_done  in  1  deskew complete, level signal.
- i_resync  in  N_LANES  per-lane resync request; the OR of all bits is used.
- i_data  in  NB_DATA_BUS  physical lanes; lane j occupies [NB_DATA_BUS-1-j*NB_DATA -: NB_DATA].
- i_lane_ids  in  NB_ID_BUS  AM-decoded logical ID of each physical lane, same MSB-first slotting.
- o_data  out  NB_DATA_BUS  lanes in logical order, registered.
- o_valid  out  1  i_valid delayed one cycle.
- o_reorder_done  out  1  high while in LOCKED.
- o_invalid_ids  out  1  one-cycle pulse: IDs at an AM cycle are not a permutation.
- o_align_error  out  1  one-cycle pulse: some but not all tags set on a valid cycle.

Behaviour:
- Reset (async): state=IDLE, all outputs 0, map=identity, mismatch_cnt=0.
- Definitions:
  - am_cycle = i_valid & (AND of all tags).
  - part_tag = i_valid & (OR of tags) & ~(AND of tags).
  - perm_ok = each value 0..N_LANES-1 appears exactly once in i_lane_ids; any ID >= N_LANES makes perm_ok=0.
- Datapath:
  - When i_enable & i_valid: o_data slot k <= i_data slot map[k], where map[k] is the physical lane whose ID is k. The tag bit travels with its data.
  - Outside LOCKED, map=identity (pass-through).
  - When i_valid is low: o_data holds, o_valid=0.
  - Latency is 1 cycle.
- IDLE:
  - Go to WAIT_AM when i_enable & i_deskew_done.
- WAIT_AM:
  - am_cycle & perm_ok: load map from i_lane_ids (inverse permutation), mismatch_cnt=0, go to LOCKED. The AM cycle itself is output pass-through; reordering starts with the next valid block.
  - am_cycle & ~perm_ok: pulse o_invalid_ids, stay in WAIT_AM.
  - part_tag: pulse o_align_error, stay in WAIT_AM.
- LOCKED:
  - am_cycle with IDs equal to the stored IDs: mismatch_cnt=0.
  - am_cycle with any ID different: mismatch_cnt+1; also pulse o_invalid_ids if ~perm_ok.
  - part_tag: pulse o_align_error and mismatch_cnt+1.
  - When mismatch_cnt reaches MAX_MISMATCH: go to WAIT_AM, map=identity, o_reorder_done=0 from the next cycle.
  - The stored map is never updated while in LOCKED.
- Any state:
  - If (OR of i_resync) or ~i_deskew_done: go to IDLE next cycle, counter cleared, map=identity. This takes priority over all other transitions.
- Simultaneous am_cycle and resync: resync wins and no pulses are generated.
- mismatch_cnt saturates at MAX_MISMATCH.

Optional Feature:
- Macro: LANE_REORDER_STATS_EN.
- Defined:
  - Adds output o_mismatch_total (16 bits).
  - Counts every mismatching AM cycle and every part_tag cycle in LOCKED.
  - Saturates at 16'hFFFF.
  - Cleared only by i_reset.
- Undefined:
  - The port and the counter are absent.
  - Behaviour is otherwise identical.

Test Plan:
- Reset mid-LOCKED: assert i_reset -> all outputs 0 immediately (async), state IDLE; after release with deskew_done=1 -> WAIT_AM.
- Reversed IDs: deskew_done=1, am_cycle with physical lane j ID=19-j -> o_reorder_done=1 next cycle; following block with lane j data=j -> o_data slot k contains 19-k.
- Duplicate ID: am_cycle with lanes 3 and 7 both ID=5 -> o_invalid_ids one-cycle pulse, o_reorder_done stays 0.
- Lost lock: in LOCKED, 3 consecutive am_cycles with lanes 0/1 IDs swapped -> o_reorder_done falls after the 3rd. With only 2 bad cycles followed by 1 good -> stays locked, counter reset.
- Partial tags: tags set on lanes 0-9 only -> o_align_error pulse; in LOCKED, mismatch_cnt increments.
- Resync: pulse i_resync[12] while LOCKED -> IDLE next cycle, pass-through data, o_reorder_done=0. With LANE_REORDER_STATS_EN, o_mismatch_total is unchanged by the resync.
